// File: rtl/procesador_riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : procesador_riscv_pkg
// Brief    : Opcode/funct encodings, ALU operations, decoder control bundle
//            and default ROM/RAM contents for the procesador_riscv core.
// Revision : 1.0 - initial release
// ============================================================================
package procesador_riscv_pkg;

    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    localparam logic [2:0] c_f3_add_sub = 3'b000;
    localparam logic [2:0] c_f3_sll     = 3'b001;
    localparam logic [2:0] c_f3_dword   = 3'b011;
    localparam logic [2:0] c_f3_xor     = 3'b100;
    localparam logic [2:0] c_f3_srl     = 3'b101;
    localparam logic [2:0] c_f3_or      = 3'b110;
    localparam logic [2:0] c_f3_and     = 3'b111;
    localparam logic [2:0] c_f3_beq     = 3'b000;
    localparam logic [2:0] c_f3_bne     = 3'b001;

    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6
    } alu_op_t;

    typedef struct packed {
        logic    reg_we;
        logic    mem_we;
        logic    alu_imm;
        logic    wb_mem;
        logic    br_eq;
        logic    br_ne;
        alu_op_t alu_op;
    } ctrl_t;

    // Entry 0 sits in the LSBs: ld x1 / ld x2 / add x3 / sd x3 / sub x4 / beq self-loop.
    localparam logic [6*32-1:0] c_rom_default = {
        32'h0000_0063,
        32'h4020_8233,
        32'h0030_3823,
        32'h0020_81B3,
        32'h0080_3103,
        32'h0000_3083
    };

    localparam logic [63:0] c_ram_word0 = 64'd5;
    localparam logic [63:0] c_ram_word1 = 64'd3;

    function automatic logic [63:0] ram_default(input int idx);
        case (idx)
            0:       return c_ram_word0;
            1:       return c_ram_word1;
            default: return 64'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/procesador_riscv_alu.sv
`default_nettype none
// ============================================================================
// Module   : procesador_riscv_alu
// Brief    : Combinational ALU with zero flag; arithmetic wraps modulo 2^BITS.
// Revision : 1.0 - initial release
// ============================================================================
module procesador_riscv_alu
    import procesador_riscv_pkg::*;
#(
    parameter int BITS = 64
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  alu_op_t         alu_op,
    output logic [BITS-1:0] result,
    output logic            zero
);

    localparam int c_sh_w = $clog2(BITS);

    logic [c_sh_w-1:0] w_shamt;

    assign w_shamt = b[c_sh_w-1:0];

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << w_shamt;
            ALU_SRL: result = a >> w_shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/procesador_riscv.sv
`default_nettype none
// ============================================================================
// Module   : procesador_riscv
// Brief    : Single-cycle RV64I-subset core with internal ROM, register file
//            and data RAM. Define PROC_ALUIMM_EN to add andi/ori/xori/slli/srli.
// Revision : 1.0 - initial release
// ============================================================================
module procesador_riscv
    import procesador_riscv_pkg::*;
#(
    parameter int                    BITS     = 64,
    parameter int                    MEM_SIZE = 16,
    parameter int                    N        = 32,
    parameter int                    NUM_INST = 6,
    parameter logic [NUM_INST*N-1:0] ROM_INIT = c_rom_default
) (
    input  logic            clk,
    input  logic            rst,
    output logic [BITS-1:0] pc
);

`ifdef PROC_ALUIMM_EN
    localparam bit c_aluimm_en = 1'b1;
`else
    localparam bit c_aluimm_en = 1'b0;
`endif

    localparam int c_idx_w  = (NUM_INST > 1) ? $clog2(NUM_INST) : 1;
    localparam int c_rom_sz = 2 ** c_idx_w;
    localparam int c_mem_aw = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic [BITS-1:0] r_pc;
    logic [BITS-1:0] r_regs [N];
    logic [BITS-1:0] r_mem  [MEM_SIZE];

    logic [N-1:0]    w_rom [c_rom_sz];
    logic            w_in_range;
    logic [N-1:0]    w_instr;
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [6:0]      w_funct7;
    logic [BITS-1:0] w_imm_i;
    logic [BITS-1:0] w_imm_s;
    logic [BITS-1:0] w_imm_b;
    logic [BITS-1:0] w_imm;
    ctrl_t           w_ctrl;
    logic [BITS-1:0] w_rs1_data;
    logic [BITS-1:0] w_rs2_data;
    logic [BITS-1:0] w_alu_b;
    logic [BITS-1:0] w_alu_res;
    logic            w_alu_zero;
    logic [c_mem_aw-1:0] w_mem_idx;
    logic [BITS-1:0] w_mem_rdata;
    logic [BITS-1:0] w_wb_data;
    logic            w_taken;
    logic [BITS-1:0] w_pc_next;

    // Unused ROM slots up to the next power of two read back as NOP.
    for (genvar gi = 0; gi < c_rom_sz; gi++) begin : g_rom
        if (gi < NUM_INST) begin : g_used
            assign w_rom[gi] = ROM_INIT[gi*N +: N];
        end else begin : g_pad
            assign w_rom[gi] = c_nop;
        end
    end

    assign w_in_range = (r_pc[BITS-1:2] < (BITS-2)'(NUM_INST));
    assign w_instr    = w_in_range ? w_rom[r_pc[c_idx_w+1:2]] : c_nop;

    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_funct3 = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_funct7 = w_instr[31:25];

    assign w_imm_i = {{(BITS-12){w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{(BITS-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{(BITS-13){w_instr[31]}}, w_instr[31], w_instr[7],
                      w_instr[30:25], w_instr[11:8], 1'b0};

    always_comb begin
        w_ctrl = '0;
        w_imm  = w_imm_i;
        case (w_opcode)
            c_op_rtype: begin
                if (w_funct7 == c_f7_base) begin
                    case (w_funct3)
                        c_f3_add_sub: begin w_ctrl.reg_we = 1'b1; w_ctrl.alu_op = ALU_ADD; end
                        c_f3_and:     begin w_ctrl.reg_we = 1'b1; w_ctrl.alu_op = ALU_AND; end
                        c_f3_or:      begin w_ctrl.reg_we = 1'b1; w_ctrl.alu_op = ALU_OR;  end
                        default:      ;
                    endcase
                end else if (w_funct7 == c_f7_alt && w_funct3 == c_f3_add_sub) begin
                    w_ctrl.reg_we = 1'b1;
                    w_ctrl.alu_op = ALU_SUB;
                end
            end
            c_op_itype: begin
                w_ctrl.alu_imm = 1'b1;
                case (w_funct3)
                    c_f3_add_sub: begin w_ctrl.reg_we = 1'b1;        w_ctrl.alu_op = ALU_ADD; end
                    c_f3_and:     begin w_ctrl.reg_we = c_aluimm_en; w_ctrl.alu_op = ALU_AND; end
                    c_f3_or:      begin w_ctrl.reg_we = c_aluimm_en; w_ctrl.alu_op = ALU_OR;  end
                    c_f3_xor:     begin w_ctrl.reg_we = c_aluimm_en; w_ctrl.alu_op = ALU_XOR; end
                    // Shifts need imm[11:6] clear; other encodings (e.g. srai) stay NOP.
                    c_f3_sll: begin
                        w_ctrl.reg_we = c_aluimm_en && (w_funct7[6:1] == 6'd0);
                        w_ctrl.alu_op = ALU_SLL;
                    end
                    c_f3_srl: begin
                        w_ctrl.reg_we = c_aluimm_en && (w_funct7[6:1] == 6'd0);
                        w_ctrl.alu_op = ALU_SRL;
                    end
                    default: ;
                endcase
            end
            c_op_load: begin
                if (w_funct3 == c_f3_dword) begin
                    w_ctrl.reg_we  = 1'b1;
                    w_ctrl.alu_imm = 1'b1;
                    w_ctrl.wb_mem  = 1'b1;
                end
            end
            c_op_store: begin
                if (w_funct3 == c_f3_dword) begin
                    w_ctrl.mem_we  = 1'b1;
                    w_ctrl.alu_imm = 1'b1;
                    w_imm          = w_imm_s;
                end
            end
            c_op_branch: begin
                w_ctrl.alu_op = ALU_SUB;
                w_ctrl.br_eq  = (w_funct3 == c_f3_beq);
                w_ctrl.br_ne  = (w_funct3 == c_f3_bne);
            end
            default: ;
        endcase
    end

    assign w_rs1_data = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2_data = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
    assign w_alu_b    = w_ctrl.alu_imm ? w_imm : w_rs2_data;

    procesador_riscv_alu #(
        .BITS(BITS)
    ) u_alu (
        .a      (w_rs1_data),
        .b      (w_alu_b),
        .alu_op (w_ctrl.alu_op),
        .result (w_alu_res),
        .zero   (w_alu_zero)
    );

    assign w_mem_idx   = w_alu_res[c_mem_aw+2:3];
    assign w_mem_rdata = r_mem[w_mem_idx];
    assign w_wb_data   = w_ctrl.wb_mem ? w_mem_rdata : w_alu_res;

    assign w_taken   = (w_ctrl.br_eq & w_alu_zero) | (w_ctrl.br_ne & ~w_alu_zero);
    assign w_pc_next = r_pc + (w_taken ? w_imm_b : BITS'(4));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_ctrl.reg_we && w_rd != 5'd0) begin
            r_regs[w_rd] <= w_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                r_mem[i] <= BITS'(ram_default(i));
            end
        end else if (w_ctrl.mem_we) begin
            r_mem[w_mem_idx] <= w_rs2_data;
        end
    end

    assign pc = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_procesador_riscv.sv
`default_nettype none
// ============================================================================
// Module   : tb_procesador_riscv
// Brief    : Scoreboard bench for procesador_riscv: default program plus an
//            alternate ROM covering x0 writes, illegal opcodes and ALU-immediates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_procesador_riscv;

    // Entry 0 in the LSBs: ld x1 / ld x2 / add x0 / illegal / ori x5 / slli x6 / beq self-loop.
    localparam logic [7*32-1:0] c_rom_b = {
        32'h0000_0063,
        32'h0042_9313,
        32'h0F00_6293,
        32'h0000_007F,
        32'h0020_8033,
        32'h0080_3103,
        32'h0000_3083
    };

`ifdef PROC_ALUIMM_EN
    localparam logic [63:0] c_exp_x5 = 64'h0F0;
    localparam logic [63:0] c_exp_x6 = 64'hF00;
`else
    localparam logic [63:0] c_exp_x5 = 64'h0;
    localparam logic [63:0] c_exp_x6 = 64'h0;
`endif

    localparam int c_pc  = 0;
    localparam int c_reg = 1;
    localparam int c_ram = 2;
    localparam int c_timeout_cycles = 2000;

    typedef struct {
        int          dut;
        int          kind;
        int          idx;
        logic [63:0] exp;
    } chk_t;

    logic        clk;
    logic        rst;
    logic [63:0] pc_a;
    logic [63:0] pc_b;

    chk_t sb_q[$];
    int   n_tests;
    int   n_fail;
    logic r_done;

    procesador_riscv dut_a (
        .clk (clk),
        .rst (rst),
        .pc  (pc_a)
    );

    procesador_riscv #(
        .NUM_INST (7),
        .ROM_INIT (c_rom_b)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .pc  (pc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] observe(input int dut, input int kind, input int idx);
        logic [4:0] ridx;
        logic [3:0] midx;
        ridx = idx[4:0];
        midx = idx[3:0];
        if (dut == 0) begin
            case (kind)
                c_pc:    return pc_a;
                c_reg:   return dut_a.r_regs[ridx];
                default: return dut_a.r_mem[midx];
            endcase
        end else begin
            case (kind)
                c_pc:    return pc_b;
                c_reg:   return dut_b.r_regs[ridx];
                default: return dut_b.r_mem[midx];
            endcase
        end
    endfunction

    task automatic expect_val(input int dut, input int kind, input int idx, input logic [63:0] exp);
        chk_t c;
        c.dut  = dut;
        c.kind = kind;
        c.idx  = idx;
        c.exp  = exp;
        sb_q.push_back(c);
    endtask

    task automatic check_reset_now();
        n_tests++;
        if (pc_a !== 64'd0 || dut_a.r_regs[1] !== 64'd0 || dut_a.r_regs[2] !== 64'd0 ||
            dut_a.r_regs[3] !== 64'd0 || dut_a.r_regs[4] !== 64'd0 || dut_a.r_mem[2] !== 64'd0) begin
            n_fail++;
            $display("FAIL async reset: state not cleared immediately (pc=0x%h)", pc_a);
        end
    endtask

    task automatic expect_a_clear();
        expect_val(0, c_pc, 0, 64'd0);
        for (int r = 1; r <= 4; r++) expect_val(0, c_reg, r, 64'd0);
        expect_val(0, c_ram, 0, 64'd5);
        expect_val(0, c_ram, 1, 64'd3);
        expect_val(0, c_ram, 2, 64'd0);
    endtask

    task automatic expect_a_done();
        expect_val(0, c_pc, 0, 64'd20);
        expect_val(0, c_reg, 0, 64'd0);
        expect_val(0, c_reg, 1, 64'd5);
        expect_val(0, c_reg, 2, 64'd3);
        expect_val(0, c_reg, 3, 64'd8);
        expect_val(0, c_reg, 4, 64'd2);
        expect_val(0, c_ram, 0, 64'd5);
        expect_val(0, c_ram, 1, 64'd3);
        expect_val(0, c_ram, 2, 64'd8);
    endtask

    task automatic expect_b_regs(input logic [63:0] x5, input logic [63:0] x6);
        expect_val(1, c_reg, 0, 64'd0);
        expect_val(1, c_reg, 1, 64'd5);
        expect_val(1, c_reg, 2, 64'd3);
        expect_val(1, c_reg, 3, 64'd0);
        expect_val(1, c_reg, 4, 64'd0);
        expect_val(1, c_reg, 5, x5);
        expect_val(1, c_reg, 6, x6);
        expect_val(1, c_ram, 0, 64'd5);
        expect_val(1, c_ram, 1, 64'd3);
        expect_val(1, c_ram, 2, 64'd0);
    endtask

    // Monitor: drains every pending expectation on the falling edge.
    initial begin
        chk_t        c;
        logic [63:0] act;
        string       nm;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                c   = sb_q.pop_front();
                act = observe(c.dut, c.kind, c.idx);
                n_tests++;
                if (act !== c.exp) begin
                    n_fail++;
                    nm = $sformatf("%s.%s%0d", (c.dut == 0) ? "a" : "b",
                                   (c.kind == c_pc) ? "pc" : (c.kind == c_reg) ? "x" : "ram",
                                   c.idx);
                    $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, c.exp);
                end
            end
        end
    end

    initial begin
        r_done = 1'b0;
        repeat (c_timeout_cycles) @(posedge clk);
        if (!r_done) begin
            n_fail++;
            $display("FAIL timeout: sequence did not complete within %0d cycles", c_timeout_cycles);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;

        repeat (2) @(posedge clk);
        expect_a_clear();
        expect_val(1, c_pc, 0, 64'd0);
        @(negedge clk); #1;

        rst = 1'b1;
        repeat (5) @(posedge clk);
        expect_a_done();
        @(negedge clk); #1;

        repeat (10) @(posedge clk);
        expect_a_done();
        expect_val(1, c_pc, 0, 64'd24);
        expect_b_regs(c_exp_x5, c_exp_x6);
        @(negedge clk); #1;

        // Reset while halted: RAM word2 held 8 and must revert without a clock edge.
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_reset_now();
        expect_a_clear();
        expect_val(1, c_pc, 0, 64'd0);
        expect_val(1, c_reg, 5, 64'd0);
        @(negedge clk); #1;

        rst = 1'b1;
        repeat (3) @(posedge clk); #2;
        rst = 1'b0;
        expect_a_clear();
        @(negedge clk); #1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        expect_val(0, c_pc, 0, 64'd12);
        expect_val(0, c_reg, 1, 64'd5);
        expect_val(0, c_reg, 2, 64'd3);
        expect_val(0, c_reg, 3, 64'd8);
        expect_val(0, c_reg, 4, 64'd0);
        expect_val(0, c_ram, 2, 64'd0);
        expect_val(1, c_pc, 0, 64'd12);
        expect_b_regs(64'd0, 64'd0);
        @(negedge clk); #1;

        repeat (1) @(posedge clk);
        expect_val(0, c_pc, 0, 64'd16);
        expect_val(0, c_ram, 2, 64'd8);
        expect_val(1, c_pc, 0, 64'd16);
        expect_b_regs(64'd0, 64'd0);
        @(negedge clk); #1;

        repeat (2) @(posedge clk);
        expect_a_done();
        expect_val(1, c_pc, 0, 64'd24);
        expect_b_regs(c_exp_x5, c_exp_x6);
        @(negedge clk); #1;

        r_done = 1'b1;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d expectations never checked", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/procesador_riscv.md
Name: procesador_riscv

Overview:
- Single-cycle RV64I-subset processor core: PC, instruction ROM, 32x64 register file, immediate generator, control decoder, ALU, branch unit and data RAM.
- Self-contained; the only inputs are clock and reset.
- It executes a fixed program held in its instruction ROM.
- It is the top of the processor subsystem and the unit exercised by the system bench.

Parameters:
- Bits, 64, datapath/register/PC width.
- MemSize, 16, data RAM depth in Bits-wide words.
- N, 32, instruction width and register count (32 registers).
- NumInst, 6, instruction ROM depth in N-bit words.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- pc  output  Bits  current program counter, for observation.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=0.
  - All registers x0..x31=0.
  - Data RAM reloads defaults: word0=5, word1=3, all other words 0.
- One instruction retires per rising clk while rst=1.
- Next PC: pc+4 by default; pc+imm_B when a branch is taken.
- Fetch: ROM index = pc[log2(NumInst)+1:2].
  - If pc/4 >= NumInst, the fetched word is NOP 0x00000013.
  - pc is not clamped.
- ROM default program, byte addresses 0..20:
  - ld x1,0(x0)
  - ld x2,8(x0)
  - add x3,x1,x2
  - sd x3,16(x0)
  - sub x4,x1,x2
  - beq x0,x0,0 (self-loop halt)
- Supported opcodes:
  - R-type 0110011: add, sub, and, or, selected by funct3/funct7[5].
  - I-type 0010011: addi only.
  - Load 0000011: ld, funct3=011.
  - Store 0100011: sd, funct3=011.
  - Branch 1100011: beq, bne.
  - Any other opcode or funct combination executes as NOP: no register write, no memory write, pc+4.
- Immediates:
  - I, S and B formats are sign-extended to Bits.
  - The B immediate has LSB 0.
- Data RAM:
  - Word index = (effective address >> 3) mod MemSize; wraps, no fault.
  - Address bits [2:0] are ignored; accesses are aligned.
  - Reads are combinational.
  - Writes happen on the rising edge.
- Register file:
  - Two combinational read ports, one write port on the rising edge.
  - Writes to x0 are discarded; x0 always reads 0.
  - Read-after-write in the same cycle returns the old value; the single-cycle design needs no forwarding.
- ALU arithmetic is modulo 2^Bits; overflow is ignored.
- Reset asserted mid-program: state returns immediately to reset values. Execution restarts at pc=0 on the first rising edge after rst=1.

Optional Feature:
- Macro PROC_ALUIMM_EN.
- Defined: I-type also decodes andi (111), ori (110), xori (100), slli (001) and srli (101), with shamt = imm[5:0].
- Undefined: these encodings execute as NOP; addi is unaffected.

Decomposition:
- Package procesador_riscv_pkg holds:
  - opcode localparams
  - funct3/funct7 constants
  - alu_op_t enum: ADD, SUB, AND, OR, XOR, SLL, SRL
  - NOP constant
  - default ROM program array
  - default data RAM init values
- Sub-module procesador_riscv_alu (inputs a, b, alu_op_t; outputs result and zero flag).
- Decoder, register file and memories stay inline in the top module.

Test Plan:
- Reset then release, 5 cycles: x1=5, x2=3, x3=8, data RAM word2=8, x4=2, pc=20.
- Halt loop: after 10 more cycles, pc stays at 20 and registers/RAM are unchanged.
- Assert rst=0 asynchronously mid-cycle at pc=12:
  - pc=0 and x1..x4=0 immediately, without waiting for a clock edge.
  - RAM word2 returns to 0.
  - After release the program reruns with identical results.
- x0 write: ROM entry add x0,x1,x2 -> x0 still reads 0, all other state is unaffected except pc+4.
- Illegal opcode 0x0000007F in ROM -> no register or RAM change, pc advances by 4.
- PROC_ALUIMM_EN build:
  - ori x5,x0,0x0F0 -> x5=0xF0.
  - slli x6,x5,4 -> x6=0xF00.
  - Without the macro, x5 and x6 stay 0.
